// File: rtl/mult_pkg.sv
// Constants and state encoding shared between the multiplier and its block reducer.
package mult_pkg;

  localparam int unsigned MEM_DEPTH  = 64;
  localparam int unsigned MEM_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COLLECT,
    DONE
  } reducer_state_t;

endpackage

// File: rtl/block_reducer_if.sv
// Request, multiplier read-stream and result handshake signals of the block reducer.
interface block_reducer_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned SW = N + $clog2(DEPTH);

  logic          EN_reduce;
  logic          RDY_reduce;
  logic          VALID_memVal;
  logic [N-1:0]  memVal_data;
  logic          EN_blockRead;
  logic          RES_valid;
  logic          RDY_result;
  logic [SW-1:0] RES_sum;
  logic [N-1:0]  RES_min;
  logic [N-1:0]  RES_max;
  logic          ERR_stray;

  modport slave (
    input  EN_reduce, VALID_memVal, memVal_data, RDY_result,
    output RDY_reduce, EN_blockRead, RES_valid, RES_sum, RES_min, RES_max, ERR_stray
  );

  modport master (
    output EN_reduce, VALID_memVal, memVal_data, RDY_result,
    input  RDY_reduce, EN_blockRead, RES_valid, RES_sum, RES_min, RES_max, ERR_stray
  );

endinterface

// File: rtl/block_reducer_datapath.sv
// Sum/min/max/beat-count registers for one block; last flags the beat that completes it.
module reduce_datapath #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned SW   = N + $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          accumulate,
  input  logic [N-1:0]  data,
  output logic [SW-1:0] sum_val,
  output logic [N-1:0]  min_val,
  output logic [N-1:0]  max_val,
  output logic          last
);

  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  logic [CW-1:0] count;

  // Count never has to hold DEPTH itself: the completing beat is recognised at DEPTH-1.
  assign last = accumulate && (count == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_val <= '0;
      min_val <= '1;
      max_val <= '0;
      count   <= '0;
    end else if (clear) begin
      sum_val <= '0;
      min_val <= '1;
      max_val <= '0;
      count   <= '0;
    end else if (accumulate) begin
      sum_val <= sum_val + SW'(data);
      if (data < min_val) min_val <= data;
      if (data > max_val) max_val <= data;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/block_reducer.sv
// Requests a block read from the multiplier, reduces the beats to sum/min/max and holds the result.
module block_reducer
  import mult_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = MEM_DEPTH
) (
  input logic            CLK,
  input logic            RST_N,
  block_reducer_if.slave bus
);

  localparam int unsigned SW = N + $clog2(DEPTH);

  reducer_state_t state;
  logic           en_block_read;
  logic           rdy_reduce;
  logic           res_valid;
  logic           err_stray;

  logic           clear;
  logic           accumulate;
  logic           stray;
  logic           last;
  logic [SW-1:0]  sum_val;
  logic [N-1:0]   min_val;
  logic [N-1:0]   max_val;

  assign clear      = (state == IDLE) && bus.EN_reduce;
  assign accumulate = ((state == REQ) || (state == COLLECT)) && bus.VALID_memVal;
  assign stray      = ((state == IDLE) || (state == DONE)) && bus.VALID_memVal;

  reduce_datapath #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_datapath (
    .clk        (CLK),
    .rst_n      (RST_N),
    .clear      (clear),
    .accumulate (accumulate),
    .data       (bus.memVal_data),
    .sum_val    (sum_val),
    .min_val    (min_val),
    .max_val    (max_val),
    .last       (last)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      en_block_read <= 1'b0;
      rdy_reduce    <= 1'b1;
      res_valid     <= 1'b0;
      err_stray     <= 1'b0;
    end else begin
      if (stray) err_stray <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.EN_reduce) begin
            state         <= REQ;
            en_block_read <= 1'b1;
            rdy_reduce    <= 1'b0;
          end
        end
        REQ: begin
          // The first beat both ends the request and may already complete a DEPTH=1 block.
          if (bus.VALID_memVal) begin
            en_block_read <= 1'b0;
            if (last) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (last) begin
            state     <= DONE;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.RDY_result) begin
            state      <= IDLE;
            res_valid  <= 1'b0;
            rdy_reduce <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.EN_blockRead = en_block_read;
  assign bus.RDY_reduce   = rdy_reduce;
  assign bus.RES_valid    = res_valid;
  assign bus.ERR_stray    = err_stray;
  assign bus.RES_sum      = sum_val;
  assign bus.RES_min      = min_val;
  assign bus.RES_max      = max_val;

endmodule
